// File: rtl/id_ex_alu_feed_pkg.sv
// ID/EX stage shared definitions: opcode/funct constants, ALU control codes, decode records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package id_ex_alu_feed_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_BAD  = 4'b1111;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       use_imm;
        logic       zext;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       dest_rd;   // 1: destination is rd (R-type), 0: rt
        logic       illegal;
    } dec_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       illegal;
        logic       use_imm;
        logic       zext;
        logic [3:0] alu_control;
    } ex_ctrl_t;

    localparam dec_t DEC_BAD = '{alu_control: ALU_BAD, use_imm: 1'b0, zext: 1'b0,
                                 regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                 dest_rd: 1'b1, illegal: 1'b1};

    function automatic dec_t mk_dec(input logic [3:0] alu, input logic use_imm,
                                    input logic zext, input logic regwrite,
                                    input logic memread, input logic memwrite,
                                    input logic dest_rd);
        dec_t d;
        d.alu_control = alu;
        d.use_imm     = use_imm;
        d.zext        = zext;
        d.regwrite    = regwrite;
        d.memread     = memread;
        d.memwrite    = memwrite;
        d.dest_rd     = dest_rd;
        d.illegal     = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/id_ex_alu_feed_alu_ctrl_decode.sv
// Opcode/funct decode into ALU control code plus per-instruction control bits.
// Latency: combinational.
// Backpressure: none; pure function of the instruction fields.
module alu_ctrl_decode
    import id_ex_alu_feed_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = DEC_BAD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: dec = mk_dec(ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    FN_SUB, FN_SUBU: dec = mk_dec(ALU_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    FN_AND:          dec = mk_dec(ALU_AND, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    FN_OR:           dec = mk_dec(ALU_OR,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    FN_NOR:          dec = mk_dec(ALU_NOR, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    FN_SLT:          dec = mk_dec(ALU_SLT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                    default:         dec = DEC_BAD;
                endcase
            end
            OP_ADDI, OP_ADDIU: dec = mk_dec(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_SLTI:           dec = mk_dec(ALU_SLT, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_ANDI:           dec = mk_dec(ALU_AND, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_ORI:            dec = mk_dec(ALU_OR,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            OP_LW:             dec = mk_dec(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            OP_SW:             dec = mk_dec(ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            // beq compares rs against rt, so operand B stays the register value
            OP_BEQ:            dec = mk_dec(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            default:           dec = DEC_BAD;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_feed.sv
// ID/EX register with operand select, EX/MEM and MEM/WB forwarding, and load-use bubble insertion.
// Latency: 1 cycle from in_* to ex_*/alu_*; forwarding muxes are combinational on the registered indices.
// Backpressure: stall holds the EX register; hazard_stall asks upstream to hold PC and IF/ID.
module id_ex_alu_feed
    import id_ex_alu_feed_pkg::*;
#(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [5:0]           in_opcode,
    input  logic [5:0]           in_funct,
    input  logic [RW-1:0]        in_rs,
    input  logic [RW-1:0]        in_rt,
    input  logic [RW-1:0]        in_rd,
    input  logic [W-1:0]         in_rs_data,
    input  logic [W-1:0]         in_rt_data,
    input  logic [15:0]          in_imm,
    input  logic                 exmem_regwrite,
    input  logic [RW-1:0]        exmem_rd,
    input  logic [W-1:0]         exmem_result,
    input  logic                 memwb_regwrite,
    input  logic [RW-1:0]        memwb_rd,
    input  logic [W-1:0]         memwb_result,
    output logic                 hazard_stall,
    output logic                 ex_valid,
    output logic [3:0]           alu_control,
    output logic signed [W-1:0]  alu_a,
    output logic signed [W-1:0]  alu_b,
    output logic [W-1:0]         store_data,
    output logic [RW-1:0]        ex_dest,
    output logic                 ex_regwrite,
    output logic                 ex_memread,
    output logic                 ex_memwrite,
    output logic                 ex_illegal
);

    dec_t           dec;
    logic [RW-1:0]  in_dest;

    ex_ctrl_t       ex_ctrl;
    logic [RW-1:0]  ex_rs;
    logic [RW-1:0]  ex_rt;
    logic [RW-1:0]  ex_dest_q;
    logic [W-1:0]   ex_rs_data;
    logic [W-1:0]   ex_rt_data;
    logic [15:0]    ex_imm;

    logic [W-1:0]   fwd_rs;
    logic [W-1:0]   fwd_rt;
    logic [W-1:0]   imm_ext;

    alu_ctrl_decode u_dec (
        .opcode (in_opcode),
        .funct  (in_funct),
        .dec    (dec)
    );

    assign in_dest = dec.dest_rd ? in_rd : in_rt;

    assign hazard_stall = in_valid && ex_ctrl.valid && ex_ctrl.memread &&
                          (ex_dest_q != '0) &&
                          ((ex_dest_q == in_rs) || (ex_dest_q == in_rt));

    always_ff @(posedge clock) begin
        if (reset || flush || (!stall && (hazard_stall || !in_valid))) begin
            ex_ctrl    <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_dest_q  <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
        end else if (!stall) begin
            ex_ctrl.valid       <= 1'b1;
            ex_ctrl.regwrite    <= dec.regwrite && (in_dest != '0);
            ex_ctrl.memread     <= dec.memread;
            ex_ctrl.memwrite    <= dec.memwrite;
            ex_ctrl.illegal     <= dec.illegal;
            ex_ctrl.use_imm     <= dec.use_imm;
            ex_ctrl.zext        <= dec.zext;
            ex_ctrl.alu_control <= dec.alu_control;
            ex_rs               <= in_rs;
            ex_rt               <= in_rt;
            ex_dest_q           <= in_dest;
            ex_rs_data          <= in_rs_data;
            ex_rt_data          <= in_rt_data;
            ex_imm              <= in_imm;
        end
    end

    // The younger EX/MEM result wins over MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_rs = ex_rs_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rs))
            fwd_rs = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs))
            fwd_rs = memwb_result;

        fwd_rt = ex_rt_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rt))
            fwd_rt = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rt))
            fwd_rt = memwb_result;
    end

    assign imm_ext = ex_ctrl.zext ? {{(W-16){1'b0}}, ex_imm}
                                  : {{(W-16){ex_imm[15]}}, ex_imm};

    assign alu_a       = fwd_rs;
    assign alu_b       = ex_ctrl.use_imm ? imm_ext : fwd_rt;
    assign store_data  = fwd_rt;
    assign ex_valid    = ex_ctrl.valid;
    assign alu_control = ex_ctrl.alu_control;
    assign ex_dest     = ex_dest_q;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_illegal  = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// Directed bench for id_ex_alu_feed: decode vector table plus reset, forwarding, hazard and stall sequences.
module tb_id_ex_alu_feed;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [5:0]  in_opcode;
    logic [5:0]  in_funct;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic [15:0] in_imm;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        hazard_stall;
    logic        ex_valid;
    logic [3:0]  alu_control;
    logic signed [31:0] alu_a;
    logic signed [31:0] alu_b;
    logic [31:0] store_data;
    logic [4:0]  ex_dest;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_illegal;

    int checks = 0;
    int errors = 0;

    id_ex_alu_feed #(.W(32), .RW(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_opcode      (in_opcode),
        .in_funct       (in_funct),
        .in_rs          (in_rs),
        .in_rt          (in_rt),
        .in_rd          (in_rd),
        .in_rs_data     (in_rs_data),
        .in_rt_data     (in_rt_data),
        .in_imm         (in_imm),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .hazard_stall   (hazard_stall),
        .ex_valid       (ex_valid),
        .alu_control    (alu_control),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .store_data     (store_data),
        .ex_dest        (ex_dest),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_illegal     (ex_illegal)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [15:0] imm;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        chk_dest;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [15:0] imm);
        in_valid   = 1'b1;
        in_opcode  = op;
        in_funct   = fn;
        in_rs      = rs;
        in_rt      = rt;
        in_rd      = rd;
        in_rs_data = rsd;
        in_rt_data = rtd;
        in_imm     = imm;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ex_valid"},    32'(ex_valid),    32'd0);
        chk({tag, ".alu_control"}, 32'(alu_control), 32'd0);
        chk({tag, ".alu_a"},       alu_a,            32'd0);
        chk({tag, ".alu_b"},       alu_b,            32'd0);
        chk({tag, ".store_data"},  store_data,       32'd0);
        chk({tag, ".ex_dest"},     32'(ex_dest),     32'd0);
        chk({tag, ".flags"},
            32'({ex_regwrite, ex_memread, ex_memwrite, ex_illegal}), 32'd0);
    endtask

    initial begin
        //          op     fn     rs  rt  rd  rsd           rtd           imm       ctl    a             b            cd dest rw mr mw il
        vecs[0]  = '{6'h00, 6'h20, 1, 2, 3, 32'd5,        32'hFFFFFFF9, 16'h0000, 4'h2, 32'd5,        32'hFFFFFFF9, 1, 3,  1, 0, 0, 0};
        vecs[1]  = '{6'h00, 6'h23, 1, 2, 4, 32'd10,       32'd3,        16'h0000, 4'h6, 32'd10,       32'd3,        1, 4,  1, 0, 0, 0};
        vecs[2]  = '{6'h00, 6'h24, 1, 2, 5, 32'h0000F0F0, 32'h0000FF00, 16'h0000, 4'h0, 32'h0000F0F0, 32'h0000FF00, 1, 5,  1, 0, 0, 0};
        vecs[3]  = '{6'h00, 6'h25, 1, 2, 6, 32'h11,       32'h22,       16'h0000, 4'h1, 32'h11,       32'h22,       1, 6,  1, 0, 0, 0};
        vecs[4]  = '{6'h00, 6'h27, 1, 2, 7, 32'h33,       32'h44,       16'h0000, 4'hC, 32'h33,       32'h44,       1, 7,  1, 0, 0, 0};
        vecs[5]  = '{6'h00, 6'h2A, 1, 2, 8, 32'h55,       32'h66,       16'h0000, 4'h7, 32'h55,       32'h66,       1, 8,  1, 0, 0, 0};
        vecs[6]  = '{6'h00, 6'h21, 1, 2, 0, 32'h1,        32'h2,        16'h0000, 4'h2, 32'h1,        32'h2,        1, 0,  0, 0, 0, 0};
        vecs[7]  = '{6'h0D, 6'h00, 1, 2, 31, 32'h1234,    32'h9,        16'hFFFF, 4'h1, 32'h1234,     32'h0000FFFF, 1, 2,  1, 0, 0, 0};
        vecs[8]  = '{6'h08, 6'h00, 1, 2, 31, 32'h1234,    32'h9,        16'hFFFF, 4'h2, 32'h1234,     32'hFFFFFFFF, 1, 2,  1, 0, 0, 0};
        vecs[9]  = '{6'h09, 6'h00, 1, 10, 0, 32'h7,       32'h9,        16'h0005, 4'h2, 32'h7,        32'h5,        1, 10, 1, 0, 0, 0};
        vecs[10] = '{6'h0C, 6'h00, 1, 2, 0, 32'h7,        32'h9,        16'h8000, 4'h0, 32'h7,        32'h00008000, 1, 2,  1, 0, 0, 0};
        vecs[11] = '{6'h0A, 6'h00, 1, 2, 0, 32'h7,        32'h9,        16'h8000, 4'h7, 32'h7,        32'hFFFF8000, 1, 2,  1, 0, 0, 0};
        vecs[12] = '{6'h23, 6'h00, 1, 9, 0, 32'h100,      32'h9,        16'h0004, 4'h2, 32'h100,      32'h4,        1, 9,  1, 1, 0, 0};
        vecs[13] = '{6'h2B, 6'h00, 1, 2, 0, 32'h100,      32'h9,        16'hFFFC, 4'h2, 32'h100,      32'hFFFFFFFC, 0, 0,  0, 0, 1, 0};
        vecs[14] = '{6'h04, 6'h00, 1, 2, 0, 32'h3,        32'h9,        16'h0010, 4'h6, 32'h3,        32'h9,        0, 0,  0, 0, 0, 0};
        vecs[15] = '{6'h00, 6'h3F, 1, 2, 3, 32'h5,        32'h6,        16'h0000, 4'hF, 32'h5,        32'h6,        0, 0,  0, 0, 0, 1};
        vecs[16] = '{6'h3F, 6'h00, 1, 2, 3, 32'h5,        32'h6,        16'h0000, 4'hF, 32'h5,        32'h6,        0, 0,  0, 0, 0, 1};
        vecs[17] = '{6'h08, 6'h00, 1, 0, 3, 32'h5,        32'h6,        16'h0001, 4'h2, 32'h5,        32'h1,        1, 0,  0, 0, 0, 0};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_opcode = '0; in_funct = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_rs_data = '0; in_rt_data = '0; in_imm = '0;
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;

        tick; tick;
        chk_zero("reset");
        reset = 1'b0;

        // Decode table: one instruction per cycle, checked the cycle after capture
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].rsd, vecs[i].rtd, vecs[i].imm);
            tick;
            chk($sformatf("v%0d.ex_valid", i),    32'(ex_valid),    32'd1);
            chk($sformatf("v%0d.alu_control", i), 32'(alu_control), 32'(vecs[i].ctl));
            chk($sformatf("v%0d.alu_a", i),       alu_a,            vecs[i].a);
            chk($sformatf("v%0d.alu_b", i),       alu_b,            vecs[i].b);
            chk($sformatf("v%0d.store_data", i),  store_data,       vecs[i].rtd);
            if (vecs[i].chk_dest)
                chk($sformatf("v%0d.ex_dest", i), 32'(ex_dest),     32'(vecs[i].dest));
            chk($sformatf("v%0d.ex_regwrite", i), 32'(ex_regwrite), 32'(vecs[i].rw));
            chk($sformatf("v%0d.ex_memread", i),  32'(ex_memread),  32'(vecs[i].mr));
            chk($sformatf("v%0d.ex_memwrite", i), 32'(ex_memwrite), 32'(vecs[i].mw));
            chk($sformatf("v%0d.ex_illegal", i),  32'(ex_illegal),  32'(vecs[i].ill));
        end

        // in_valid low loads a bubble
        in_valid = 1'b0;
        tick;
        chk_zero("invalid");

        // Reset mid-stream
        drive(6'h00, 6'h20, 1, 2, 3, 32'd5, 32'd6, 16'h0);
        tick;
        chk("pre_reset.ex_valid", 32'(ex_valid), 32'd1);
        reset = 1'b1;
        tick; tick;
        chk_zero("midreset");
        reset = 1'b0;

        // Forwarding on rs=4 and rt=5
        drive(6'h00, 6'h20, 4, 5, 7, 32'd100, 32'd200, 16'h0);
        exmem_regwrite = 1'b1; exmem_rd = 4; exmem_result = 32'd9;
        memwb_regwrite = 1'b1; memwb_rd = 4; memwb_result = 32'd7;
        tick;
        chk("fwd.both_match", alu_a, 32'd9);
        chk("fwd.rt_unmatched", alu_b, 32'd200);
        exmem_rd = 0; memwb_rd = 0;
        #1;
        chk("fwd.rd0_regval", alu_a, 32'd100);
        memwb_rd = 4;
        #1;
        chk("fwd.memwb_only", alu_a, 32'd7);
        exmem_regwrite = 1'b0; exmem_rd = 4;
        #1;
        chk("fwd.exmem_norw", alu_a, 32'd7);
        exmem_regwrite = 1'b1; exmem_rd = 5; memwb_rd = 0;
        #1;
        chk("fwd.rt_alu_b", alu_b, 32'd9);
        chk("fwd.rt_store", store_data, 32'd9);
        chk("fwd.rs_regval", alu_a, 32'd100);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0; exmem_rd = 0; memwb_rd = 0;

        // Load-use hazard
        drive(6'h23, 6'h00, 1, 8, 0, 32'h40, 32'h0, 16'h0);
        tick;
        chk("lu.lw_memread", 32'(ex_memread), 32'd1);
        drive(6'h00, 6'h20, 8, 2, 5, 32'd1, 32'd2, 16'h0);
        #1;
        chk("lu.hazard_on", 32'(hazard_stall), 32'd1);
        tick;
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu.bubble_ctl", 32'(alu_control), 32'd0);
        chk("lu.hazard_off", 32'(hazard_stall), 32'd0);
        tick;
        chk("lu.add_valid", 32'(ex_valid), 32'd1);
        chk("lu.add_dest", 32'(ex_dest), 32'd5);

        // Stall holds for 3 cycles; forwarding still recomputes
        drive(6'h00, 6'h20, 1, 2, 6, 32'd11, 32'd22, 16'h0);
        tick;
        stall = 1'b1;
        drive(6'h00, 6'h22, 3, 4, 9, 32'd33, 32'd44, 16'h0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk($sformatf("stall%0d.ex_dest", c),     32'(ex_dest),     32'd6);
            chk($sformatf("stall%0d.alu_control", c), 32'(alu_control), 32'h2);
            chk($sformatf("stall%0d.alu_a", c),       alu_a,            32'd11);
        end
        exmem_regwrite = 1'b1; exmem_rd = 1; exmem_result = 32'd77;
        #1;
        chk("stall.fwd_alu_a", alu_a, 32'd77);
        chk("stall.fwd_dest", 32'(ex_dest), 32'd6);
        exmem_regwrite = 1'b0; exmem_rd = 0;

        // Flush wins over stall
        flush = 1'b1;
        tick;
        chk("flush.ex_valid", 32'(ex_valid), 32'd0);
        chk("flush.alu_control", 32'(alu_control), 32'd0);
        chk("flush.ex_dest", 32'(ex_dest), 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        in_valid = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
